// File: rtl/trap_csr_unit_if.sv
// Trap handler / CSR execution unit connection bundle for trap_csr_unit.
// The master side drives the trap, xret and CSR requests; the slave side returns the trap control view.
interface trap_csr_unit_if;
    logic        IN_trapValid;
    logic [31:0] IN_trapPC;
    logic [3:0]  IN_trapCause;
    logic        IN_trapDelegate;
    logic        IN_trapIsInterrupt;
    logic        IN_xretValid;
    logic        IN_xretIsSret;
    logic        IN_retIsSret;
    logic        IN_csrWe;
    logic [11:0] IN_csrAddr;
    logic [31:0] IN_csrWData;
    logic [2:0]  IN_irq;
    logic [31:0] OUT_csrRData;
    logic        OUT_csrIllegal;
    logic [1:0]  OUT_priv;
    logic [29:0] OUT_mtvec;
    logic [29:0] OUT_stvec;
    logic [30:0] OUT_retvec;
    logic [15:0] OUT_mideleg;
    logic [15:0] OUT_medeleg;
    logic        OUT_interruptPending;
    logic [3:0]  OUT_interruptCause;
    logic        OUT_interruptDelegate;

    modport master (
        output IN_trapValid, IN_trapPC, IN_trapCause, IN_trapDelegate, IN_trapIsInterrupt,
               IN_xretValid, IN_xretIsSret, IN_retIsSret, IN_csrWe, IN_csrAddr, IN_csrWData, IN_irq,
        input  OUT_csrRData, OUT_csrIllegal, OUT_priv, OUT_mtvec, OUT_stvec, OUT_retvec,
               OUT_mideleg, OUT_medeleg, OUT_interruptPending, OUT_interruptCause, OUT_interruptDelegate
    );

    modport slave (
        input  IN_trapValid, IN_trapPC, IN_trapCause, IN_trapDelegate, IN_trapIsInterrupt,
               IN_xretValid, IN_xretIsSret, IN_retIsSret, IN_csrWe, IN_csrAddr, IN_csrWData, IN_irq,
        output OUT_csrRData, OUT_csrIllegal, OUT_priv, OUT_mtvec, OUT_stvec, OUT_retvec,
               OUT_mideleg, OUT_medeleg, OUT_interruptPending, OUT_interruptCause, OUT_interruptDelegate
    );
endinterface

// File: rtl/trap_csr_unit.sv
// Machine/supervisor trap state: privilege, status bits, epc/cause/tvec, delegation and interrupt arbitration.
// CSR port is combinational on read and applies writes at the clock edge; trap/xret updates override overlapping fields.
module trap_csr_unit #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input logic          clk,
    input logic          rst,
    trap_csr_unit_if.slave bus
);
    typedef enum logic [1:0] {
        PRIV_U = 2'd0,
        PRIV_S = 2'd1,
        PRIV_M = 2'd3
    } priv_e;

    localparam logic [15:0] IRQ_MASK     = 16'h0AAA;
    localparam logic [15:0] S_IRQ_MASK   = 16'h0222;
    localparam logic [15:0] MEDELEG_MASK = 16'hF7FF;

    priv_e       priv;
    logic        st_mie, st_sie, st_mpie, st_spie, st_spp;
    logic [1:0]  st_mpp;
    logic [31:1] mepc, sepc;
    logic [31:2] mtvec, stvec;
    logic        mcause_int, scause_int;
    logic [3:0]  mcause_code, scause_code;
    logic [15:0] mie_r, mideleg, medeleg, soft_ip;
    logic [31:0] mscratch, sscratch;
    logic        int_pending, int_delegate;
    logic [3:0]  int_cause;

    logic [31:0] mstatus_rd, rdata;
    logic [15:0] mip_v, pend, m_cand, s_cand;
    logic [4:0]  m_pick, s_pick;
    logic        hit, illegal, csr_wr;
    logic [31:0] wd;
    logic        unused_pc0;

    assign wd         = bus.IN_csrWData;
    assign unused_pc0 = bus.IN_trapPC[0];

    assign mstatus_rd = {19'b0, st_mpp, 2'b0, st_spp, st_mpie, 1'b0, st_spie, 1'b0,
                         st_mie, 1'b0, st_sie, 1'b0};
    assign mip_v = soft_ip | {4'b0, bus.IN_irq[2], 3'b0, bus.IN_irq[1], 3'b0, bus.IN_irq[0], 3'b0};

    always_comb begin
        rdata = '0;
        hit   = 1'b1;
        unique case (bus.IN_csrAddr)
            12'h300: rdata = mstatus_rd;
            12'h100: rdata = mstatus_rd & 32'h0000_0122;
            12'h302: rdata = {16'b0, medeleg};
            12'h303: rdata = {16'b0, mideleg};
            12'h304: rdata = {16'b0, mie_r};
            12'h104: rdata = {16'b0, mie_r & S_IRQ_MASK};
            12'h305: rdata = {mtvec, 2'b0};
            12'h105: rdata = {stvec, 2'b0};
            12'h340: rdata = mscratch;
            12'h140: rdata = sscratch;
            12'h341: rdata = {mepc, 1'b0};
            12'h141: rdata = {sepc, 1'b0};
            12'h342: rdata = {mcause_int, 27'b0, mcause_code};
            12'h142: rdata = {scause_int, 27'b0, scause_code};
            12'h344: rdata = {16'b0, mip_v};
            12'h144: rdata = {16'b0, mip_v & S_IRQ_MASK};
            default: hit = 1'b0;
        endcase
    end

    assign illegal = !hit || (bus.IN_csrAddr[9:8] > priv);
    assign csr_wr  = bus.IN_csrWe && !illegal;

    // Fixed priority within a level: 11, 3, 7, 9, 1, 5; bit 4 flags a winner.
    function automatic logic [4:0] pick(input logic [15:0] v);
        logic [4:0] r;
        r = '0;
        if (v[11])     r = {1'b1, 4'd11};
        else if (v[3]) r = {1'b1, 4'd3};
        else if (v[7]) r = {1'b1, 4'd7};
        else if (v[9]) r = {1'b1, 4'd9};
        else if (v[1]) r = {1'b1, 4'd1};
        else if (v[5]) r = {1'b1, 4'd5};
        return r;
    endfunction

    assign pend   = mip_v & mie_r;
    assign m_cand = ((priv != PRIV_M) || st_mie) ? (pend & ~mideleg) : '0;
    assign s_cand = ((priv == PRIV_U) || ((priv == PRIV_S) && st_sie)) ? (pend & mideleg) : '0;
    assign m_pick = pick(m_cand);
    assign s_pick = pick(s_cand);

    // CSR write first so a same-cycle trap/xret overrides the fields it owns, using pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            priv         <= PRIV_M;
            st_mie       <= 1'b0;
            st_sie       <= 1'b0;
            st_mpie      <= 1'b0;
            st_spie      <= 1'b0;
            st_spp       <= 1'b0;
            st_mpp       <= PRIV_U;
            mepc         <= '0;
            sepc         <= '0;
            mcause_int   <= 1'b0;
            mcause_code  <= '0;
            scause_int   <= 1'b0;
            scause_code  <= '0;
            mtvec        <= MTVEC_RESET[31:2];
            stvec        <= '0;
            mie_r        <= '0;
            mideleg      <= '0;
            medeleg      <= '0;
            soft_ip      <= '0;
            mscratch     <= '0;
            sscratch     <= '0;
            int_pending  <= 1'b0;
            int_cause    <= '0;
            int_delegate <= 1'b0;
        end else begin
            if (csr_wr) begin
                unique case (bus.IN_csrAddr)
                    12'h300: begin
                        st_sie  <= wd[1];
                        st_mie  <= wd[3];
                        st_spie <= wd[5];
                        st_mpie <= wd[7];
                        st_spp  <= wd[8];
                        st_mpp  <= (wd[12:11] == 2'b10) ? 2'b00 : wd[12:11];
                    end
                    12'h100: begin
                        st_sie  <= wd[1];
                        st_spie <= wd[5];
                        st_spp  <= wd[8];
                    end
                    12'h302: medeleg <= wd[15:0] & MEDELEG_MASK;
                    12'h303: mideleg <= wd[15:0] & IRQ_MASK;
                    12'h304: mie_r <= wd[15:0] & IRQ_MASK;
                    12'h104: mie_r <= (mie_r & ~S_IRQ_MASK) | (wd[15:0] & S_IRQ_MASK);
                    12'h305: mtvec <= wd[31:2];
                    12'h105: stvec <= wd[31:2];
                    12'h340: mscratch <= wd;
                    12'h140: sscratch <= wd;
                    12'h341: mepc <= wd[31:1];
                    12'h141: sepc <= wd[31:1];
                    12'h342: begin
                        mcause_int  <= wd[31];
                        mcause_code <= wd[3:0];
                    end
                    12'h142: begin
                        scause_int  <= wd[31];
                        scause_code <= wd[3:0];
                    end
                    12'h344, 12'h144: soft_ip <= wd[15:0] & S_IRQ_MASK;
                    default: ;
                endcase
            end

            if (bus.IN_trapValid) begin
                if (bus.IN_trapDelegate) begin
                    sepc        <= bus.IN_trapPC[31:1];
                    scause_int  <= bus.IN_trapIsInterrupt;
                    scause_code <= bus.IN_trapCause;
                    st_spie     <= st_sie;
                    st_sie      <= 1'b0;
                    st_spp      <= priv[0];
                    priv        <= PRIV_S;
                end else begin
                    mepc        <= bus.IN_trapPC[31:1];
                    mcause_int  <= bus.IN_trapIsInterrupt;
                    mcause_code <= bus.IN_trapCause;
                    st_mpie     <= st_mie;
                    st_mie      <= 1'b0;
                    st_mpp      <= priv;
                    priv        <= PRIV_M;
                end
            end else if (bus.IN_xretValid) begin
                if (bus.IN_xretIsSret) begin
                    priv    <= st_spp ? PRIV_S : PRIV_U;
                    st_sie  <= st_spie;
                    st_spie <= 1'b1;
                    st_spp  <= 1'b0;
                end else begin
                    priv    <= priv_e'(st_mpp);
                    st_mie  <= st_mpie;
                    st_mpie <= 1'b1;
                    st_mpp  <= PRIV_U;
                end
            end

            if (m_pick[4]) begin
                int_pending  <= 1'b1;
                int_cause    <= m_pick[3:0];
                int_delegate <= 1'b0;
            end else if (s_pick[4]) begin
                int_pending  <= 1'b1;
                int_cause    <= s_pick[3:0];
                int_delegate <= 1'b1;
            end else begin
                int_pending  <= 1'b0;
                int_cause    <= '0;
                int_delegate <= 1'b0;
            end
        end
    end

    assign bus.OUT_csrRData          = rdata;
    assign bus.OUT_csrIllegal        = illegal;
    assign bus.OUT_priv              = priv;
    assign bus.OUT_mtvec             = mtvec;
    assign bus.OUT_stvec             = stvec;
    assign bus.OUT_retvec            = bus.IN_retIsSret ? sepc : mepc;
    assign bus.OUT_mideleg           = mideleg;
    assign bus.OUT_medeleg           = medeleg;
    assign bus.OUT_interruptPending  = int_pending;
    assign bus.OUT_interruptCause    = int_cause;
    assign bus.OUT_interruptDelegate = int_delegate;
endmodule

// File: tb/tb_trap_csr_unit.sv
// Scoreboard bench for trap_csr_unit: directed spec scenarios then random traffic against a word-level model.
module tb_trap_csr_unit;
    localparam logic [31:0] MTVEC_INIT = 32'h8000_0103;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    trap_csr_unit_if bus ();
    trap_csr_unit #(.MTVEC_RESET(MTVEC_INIT)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic        rst, trap, del, isint, xret, xsret, retsret, we;
        logic [31:0] pc, wdata;
        logic [3:0]  cause;
        logic [11:0] addr;
        logic [2:0]  irq;
    } stim_t;

    typedef struct {
        logic        legal;
        logic [31:0] rdata;
        logic [1:0]  priv;
        logic [30:0] retvec;
        logic [29:0] mtvec, stvec;
        logic [15:0] mideleg, medeleg;
        logic        ip, id;
        logic [3:0]  ic;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;

    // Reference model: CSRs kept as architectural 32-bit words.
    logic [31:0] m_ms, m_mepc, m_sepc, m_mcause, m_scause, m_mtvec, m_stvec;
    logic [31:0] m_medeleg, m_mideleg, m_mie, m_soft, m_mscr, m_sscr;
    logic [1:0]  m_priv;
    logic        m_ip, m_id;
    logic [3:0]  m_ic;

    task automatic model_reset();
        m_priv = 2'd3; m_ms = '0; m_mepc = '0; m_sepc = '0; m_mcause = '0; m_scause = '0;
        m_mtvec = MTVEC_INIT & ~32'h3; m_stvec = '0; m_medeleg = '0; m_mideleg = '0;
        m_mie = '0; m_soft = '0; m_mscr = '0; m_sscr = '0; m_ip = 1'b0; m_ic = '0; m_id = 1'b0;
    endtask

    function automatic logic [31:0] mip_of(input logic [2:0] irq);
        return m_soft | (32'(irq[2]) << 11) | (32'(irq[1]) << 7) | (32'(irq[0]) << 3);
    endfunction

    function automatic logic model_read(input logic [11:0] a, input logic [2:0] irq, output logic [31:0] d);
        logic hit;
        hit = 1'b1;
        d = '0;
        case (a)
            12'h300: d = m_ms;
            12'h100: d = m_ms & 32'h122;
            12'h302: d = m_medeleg;
            12'h303: d = m_mideleg;
            12'h304: d = m_mie;
            12'h104: d = m_mie & 32'h222;
            12'h305: d = m_mtvec;
            12'h105: d = m_stvec;
            12'h340: d = m_mscr;
            12'h140: d = m_sscr;
            12'h341: d = m_mepc;
            12'h141: d = m_sepc;
            12'h342: d = m_mcause;
            12'h142: d = m_scause;
            12'h344: d = mip_of(irq);
            12'h144: d = mip_of(irq) & 32'h222;
            default: hit = 1'b0;
        endcase
        return hit && (32'(a[9:8]) <= 32'(m_priv));
    endfunction

    task automatic model_write(input logic [11:0] a, input logic [31:0] w);
        case (a)
            12'h300: begin
                m_ms = w & 32'h19AA;
                if (m_ms[12:11] == 2'b10) m_ms[12:11] = 2'b00;
            end
            12'h100: m_ms = (m_ms & ~32'h122) | (w & 32'h122);
            12'h302: m_medeleg = w & 32'hF7FF;
            12'h303: m_mideleg = w & 32'hAAA;
            12'h304: m_mie = w & 32'hAAA;
            12'h104: m_mie = (m_mie & ~32'h222) | (w & 32'h222);
            12'h305: m_mtvec = w & ~32'h3;
            12'h105: m_stvec = w & ~32'h3;
            12'h340: m_mscr = w;
            12'h140: m_sscr = w;
            12'h341: m_mepc = w & ~32'h1;
            12'h141: m_sepc = w & ~32'h1;
            12'h342: m_mcause = {w[31], 27'b0, w[3:0]};
            12'h142: m_scause = {w[31], 27'b0, w[3:0]};
            12'h344, 12'h144: m_soft = w & 32'h222;
            default: ;
        endcase
    endtask

    task automatic model_edge(input stim_t s);
        logic [31:0] old_ms, p, dummy;
        logic [1:0]  old_priv;
        logic        men, sen, np, nd, legal;
        logic [3:0]  nc;
        int          order[6];
        if (s.rst) begin
            model_reset();
            return;
        end
        order = '{11, 3, 7, 9, 1, 5};
        old_ms = m_ms;
        old_priv = m_priv;
        p = mip_of(s.irq) & m_mie;
        men = (m_priv != 2'd3) || m_ms[3];
        sen = (m_priv == 2'd0) || (m_priv == 2'd1 && m_ms[1]);
        np = 1'b0; nd = 1'b0; nc = '0;
        if (men)
            foreach (order[k])
                if (!np && p[order[k]] && !m_mideleg[order[k]]) begin np = 1'b1; nc = 4'(order[k]); end
        if (!np && sen)
            foreach (order[k])
                if (!np && p[order[k]] && m_mideleg[order[k]]) begin np = 1'b1; nc = 4'(order[k]); nd = 1'b1; end
        legal = model_read(s.addr, s.irq, dummy);
        if (s.we && legal) model_write(s.addr, s.wdata);
        if (s.trap) begin
            if (s.del) begin
                m_sepc = s.pc & ~32'h1;
                m_scause = {s.isint, 27'b0, s.cause};
                m_ms[5] = old_ms[1];
                m_ms[1] = 1'b0;
                m_ms[8] = old_priv[0];
                m_priv = 2'd1;
            end else begin
                m_mepc = s.pc & ~32'h1;
                m_mcause = {s.isint, 27'b0, s.cause};
                m_ms[7] = old_ms[3];
                m_ms[3] = 1'b0;
                m_ms[12:11] = old_priv;
                m_priv = 2'd3;
            end
        end else if (s.xret) begin
            if (s.xsret) begin
                m_priv = {1'b0, old_ms[8]};
                m_ms[1] = old_ms[5];
                m_ms[5] = 1'b1;
                m_ms[8] = 1'b0;
            end else begin
                m_priv = old_ms[12:11];
                m_ms[3] = old_ms[7];
                m_ms[7] = 1'b1;
                m_ms[12:11] = 2'b00;
            end
        end
        m_ip = np; m_ic = nc; m_id = nd;
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.rst = 1'b0; s.trap = 1'b0; s.del = 1'b0; s.isint = 1'b0; s.xret = 1'b0;
        s.xsret = 1'b0; s.retsret = 1'b0; s.we = 1'b0; s.pc = '0; s.wdata = '0;
        s.cause = '0; s.addr = 12'h305; s.irq = '0;
        return s;
    endfunction

    task automatic step(input stim_t s, input bit check);
        exp_t e;
        @(posedge clk);
        #1;
        rst = s.rst;
        bus.IN_trapValid = s.trap; bus.IN_trapPC = s.pc; bus.IN_trapCause = s.cause;
        bus.IN_trapDelegate = s.del; bus.IN_trapIsInterrupt = s.isint;
        bus.IN_xretValid = s.xret; bus.IN_xretIsSret = s.xsret; bus.IN_retIsSret = s.retsret;
        bus.IN_csrWe = s.we; bus.IN_csrAddr = s.addr; bus.IN_csrWData = s.wdata; bus.IN_irq = s.irq;
        if (check) begin
            e.legal = model_read(s.addr, s.irq, e.rdata);
            e.priv = m_priv;
            e.retvec = s.retsret ? m_sepc[31:1] : m_mepc[31:1];
            e.mtvec = m_mtvec[31:2];
            e.stvec = m_stvec[31:2];
            e.mideleg = m_mideleg[15:0];
            e.medeleg = m_medeleg[15:0];
            e.ip = m_ip; e.ic = m_ic; e.id = m_id;
            exp_q.push_back(e);
        end
        model_edge(s);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("illegal", 32'(bus.OUT_csrIllegal), 32'(!e.legal));
            if (e.legal) chk("rdata", bus.OUT_csrRData, e.rdata);
            chk("priv", 32'(bus.OUT_priv), 32'(e.priv));
            chk("retvec", 32'(bus.OUT_retvec), 32'(e.retvec));
            chk("mtvec", 32'(bus.OUT_mtvec), 32'(e.mtvec));
            chk("stvec", 32'(bus.OUT_stvec), 32'(e.stvec));
            chk("mideleg", 32'(bus.OUT_mideleg), 32'(e.mideleg));
            chk("medeleg", 32'(bus.OUT_medeleg), 32'(e.medeleg));
            chk("int_pending", 32'(bus.OUT_interruptPending), 32'(e.ip));
            chk("int_cause", 32'(bus.OUT_interruptCause), 32'(e.ic));
            chk("int_delegate", 32'(bus.OUT_interruptDelegate), 32'(e.id));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        stim_t s;
        logic [11:0] addrs[19];
        int drain;
        addrs = '{12'h300, 12'h302, 12'h303, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344,
                  12'h100, 12'h104, 12'h105, 12'h140, 12'h141, 12'h142, 12'h144, 12'h7C0, 12'h301, 12'h000};
        model_reset();

        s = idle(); s.rst = 1'b1;
        step(s, 0); step(s, 0);
        s = idle(); step(s, 1);                                        // reset view: mtvec, priv, pending
        s = idle(); s.we = 1; s.addr = 12'h302; s.wdata = '1; step(s, 1);
        s = idle(); s.addr = 12'h302; step(s, 1);                      // bit 11 reads 0
        s = idle(); s.we = 1; s.addr = 12'h302; s.wdata = 32'h100; step(s, 1);
        s = idle(); s.xret = 1; step(s, 1);                            // mret to U
        s = idle(); s.addr = 12'h300; step(s, 1);
        s = idle(); s.we = 1; s.addr = 12'h7C0; s.wdata = '1; step(s, 1);
        s = idle(); s.we = 1; s.addr = 12'h300; s.wdata = 32'h8; step(s, 1);
        s = idle(); s.trap = 1; s.del = 1; s.cause = 4'd8; s.pc = 32'h1002; step(s, 1);
        s = idle(); s.addr = 12'h141; s.retsret = 1; step(s, 1);
        s = idle(); s.addr = 12'h100; step(s, 1);
        s = idle(); s.trap = 1; s.cause = 4'd9; s.pc = 32'h2000; step(s, 1);
        s = idle(); s.we = 1; s.addr = 12'h300; s.wdata = 32'h8; step(s, 1);
        s = idle(); s.trap = 1; s.cause = 4'd2; s.pc = 32'h80; step(s, 1);
        s = idle(); s.addr = 12'h300; step(s, 1);
        s = idle(); s.xret = 1; s.addr = 12'h341; step(s, 1);
        s = idle(); s.addr = 12'h300; step(s, 1);                      // retvec 0x40, MIE restored
        s = idle(); s.we = 1; s.addr = 12'h304; s.wdata = 32'h888; step(s, 1);
        s = idle(); s.irq = 3'b111; step(s, 1); step(s, 1); step(s, 1);
        s = idle(); s.we = 1; s.addr = 12'h300; s.wdata = 32'h8; step(s, 1);
        s = idle(); s.trap = 1; s.we = 1; s.addr = 12'h300; s.wdata = 32'h8; s.pc = 32'h44; step(s, 1);
        s = idle(); s.addr = 12'h300; step(s, 1);                      // MIE=0, MPIE=old MIE
        s = idle(); s.we = 1; s.addr = 12'h303; s.wdata = 32'h222; step(s, 1);
        s = idle(); s.we = 1; s.addr = 12'h304; s.wdata = 32'h222; step(s, 1);
        s = idle(); s.we = 1; s.addr = 12'h344; s.wdata = '1; step(s, 1);
        s = idle(); s.we = 1; s.addr = 12'h300; s.wdata = 32'h800; step(s, 1);
        s = idle(); s.xret = 1; step(s, 1);                            // to S with SIE=0
        s = idle(); s.we = 1; s.addr = 12'h100; s.wdata = 32'h2; step(s, 1);
        s = idle(); s.addr = 12'h144; step(s, 1); step(s, 1);          // S-level pending, delegated
        s = idle(); s.rst = 1; s.trap = 1; s.pc = 32'h500; step(s, 1);
        s = idle(); s.addr = 12'h341; step(s, 1); step(s, 1);

        for (int i = 0; i < 400; i++) begin
            s = idle();
            s.rst = ($urandom_range(0, 99) == 0);
            s.trap = ($urandom_range(0, 9) == 0);
            s.del = $urandom_range(0, 1);
            s.isint = $urandom_range(0, 1);
            s.cause = 4'($urandom);
            s.pc = $urandom;
            s.xret = ($urandom_range(0, 7) == 0);
            s.xsret = $urandom_range(0, 1);
            s.retsret = $urandom_range(0, 1);
            s.we = $urandom_range(0, 1);
            s.addr = addrs[$urandom_range(0, 18)];
            s.wdata = $urandom;
            s.irq = 3'($urandom);
            step(s, 1);
        end
        s = idle();
        step(s, 0);
        drain = 0;
        while (exp_q.size() != 0 && drain < 20) begin
            @(posedge clk);
            drain++;
        end
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
